// File: rtl/fio_seq_pkg.sv
// Shared encodings for the FileIO sequencer: host command codes, FSM states
// and the payload widths of each FIO target.
package fio_seq_pkg;

  localparam logic [2:0] CMD_TM     = 3'd0;
  localparam logic [2:0] CMD_ICACHE = 3'd1;
  localparam logic [2:0] CMD_MEM    = 3'd2;
  localparam logic [2:0] CMD_CLE    = 3'd3;
  localparam logic [2:0] CMD_GO     = 3'd4;
  localparam logic [2:0] CMD_CLEAR  = 3'd5;

  localparam int TM_DATA_W     = 29;
  localparam int ICACHE_DATA_W = 32;
  localparam int MEM_DATA_W    = 256;
  localparam int CLE_DATA_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_CAP,
    ST_DUMP_OUT
  } fio_state_e;

endpackage

// File: rtl/fio_dump_reader.sv
// Streams MEM words 0..DUMP_WORDS-1 out of the synchronous BRAM port:
// present address, capture BRAM output, hold until the consumer accepts.
module fio_dump_reader
  import fio_seq_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DUMP_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [MEM_DATA_W-1:0] mem_dout,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [MEM_DATA_W-1:0] dump_data,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_WORDS - 1);

  fio_state_e            r_state;
  logic [ADDR_W-1:0]     r_index;
  logic                  r_dump_valid;
  logic [MEM_DATA_W-1:0] r_dump_data;

  logic w_handshake;
  logic w_last;

  assign w_handshake = (r_state == ST_DUMP_OUT) && dump_ready;
  assign w_last      = (r_index == LAST_IDX);

  // rd_req tells the top to load its registered MEM address with rd_addr,
  // so the address is on the BRAM port during the following DUMP_RD cycle.
  assign rd_req  = ((r_state == ST_IDLE) && start) || (w_handshake && !w_last);
  assign rd_addr = (r_state == ST_IDLE) ? '0 : r_index + 1'b1;
  assign done    = w_handshake && w_last;

  assign dump_valid = r_dump_valid;
  assign dump_data  = r_dump_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_index      <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_index <= '0;
            r_state <= ST_DUMP_RD;
          end
        end
        ST_DUMP_RD: begin
          r_state <= ST_DUMP_CAP;
        end
        ST_DUMP_CAP: begin
          r_dump_data  <= mem_dout;
          r_dump_valid <= 1'b1;
          r_state      <= ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (dump_ready) begin
            r_dump_valid <= 1'b0;
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_index <= r_index + 1'b1;
              r_state <= ST_DUMP_RD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fio_sequencer.sv
// Host-driven load/run/dump sequencer for the GPU FIO ports.
// Optional RUN watchdog enabled by defining FIO_WATCHDOG_EN.
module fio_sequencer
  import fio_seq_pkg::*;
#(
  parameter int MEM_ADDR_W    = 9,
  parameter int ICACHE_ADDR_W = 10,
  parameter int CLE_ADDR_W    = 8,
  parameter int DUMP_WORDS    = 256,
  parameter int WDOG_CYCLES   = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [2:0]               host_cmd,
  input  logic [255:0]             host_data,
  output logic                     Wen_FIO_TM,
  output logic [TM_DATA_W-1:0]     Din_FIO_TM,
  output logic                     start_FIO_TM,
  output logic                     clear_FIO_TM,
  input  logic                     finished_TM_FIO,
  output logic                     Wen_FIO_ICache,
  output logic [ICACHE_ADDR_W-1:0] Addr_FIO_ICache,
  output logic [ICACHE_DATA_W-1:0] Din_FIO_ICache,
  output logic                     Wen_FIO_MEM,
  output logic [MEM_ADDR_W-1:0]    Addr_FIO_MEM,
  output logic [MEM_DATA_W-1:0]    Din_FIO_MEM,
  input  logic [MEM_DATA_W-1:0]    Dout_FIO_MEM,
  output logic                     Wen_FIO_CLE,
  output logic [CLE_ADDR_W-1:0]    Addr_FIO_CLE,
  output logic [CLE_DATA_W-1:0]    Din_FIO_CLE,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [MEM_DATA_W-1:0]    dump_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     timeout
);

  fio_state_e r_state;

  logic [ICACHE_ADDR_W-1:0] r_ic_ptr;
  logic [MEM_ADDR_W-1:0]    r_mem_ptr;
  logic [CLE_ADDR_W-1:0]    r_cle_ptr;

  logic                     r_host_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_overflow;
  logic                     r_start_tm;
  logic                     r_clear_tm;
  logic                     r_wen_tm;
  logic [TM_DATA_W-1:0]     r_din_tm;
  logic                     r_wen_ic;
  logic [ICACHE_ADDR_W-1:0] r_addr_ic;
  logic [ICACHE_DATA_W-1:0] r_din_ic;
  logic                     r_wen_mem;
  logic [MEM_ADDR_W-1:0]    r_addr_mem;
  logic [MEM_DATA_W-1:0]    r_din_mem;
  logic                     r_wen_cle;
  logic [CLE_ADDR_W-1:0]    r_addr_cle;
  logic [CLE_DATA_W-1:0]    r_din_cle;

  logic                     w_accept;
  logic                     w_clear_cmd;
  logic                     w_wdog_expire;
  logic                     w_dump_start;
  logic                     w_rd_req;
  logic [MEM_ADDR_W-1:0]    w_rd_addr;
  logic                     w_dump_done;

  assign w_accept     = host_valid && r_host_ready;
  assign w_clear_cmd  = w_accept && (host_cmd == CMD_CLEAR);
  assign w_dump_start = (r_state == ST_RUN) && (finished_TM_FIO || w_wdog_expire);

`ifdef FIO_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_timeout;

  assign w_wdog_expire = (r_state == ST_RUN) && !finished_TM_FIO &&
                         (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign timeout = r_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wdog_cnt <= (r_state == ST_RUN) ? r_wdog_cnt + 1'b1 : '0;
      if (w_clear_cmd) begin
        r_timeout <= 1'b0;
      end else if (w_wdog_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_wdog_expire = 1'b0;
  assign timeout       = 1'b0;
`endif

  fio_dump_reader #(
    .ADDR_W     (MEM_ADDR_W),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump_reader (
    .clk        (clk),
    .rst        (rst),
    .start      (w_dump_start),
    .rd_req     (w_rd_req),
    .rd_addr    (w_rd_addr),
    .mem_dout   (Dout_FIO_MEM),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .done       (w_dump_done)
  );

  // The top FSM parks in ST_DUMP_RD for the whole dump; the reader owns the
  // RD/CAP/OUT sub-phases and reports completion through w_dump_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_ic_ptr     <= '0;
      r_mem_ptr    <= '0;
      r_cle_ptr    <= '0;
      r_host_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_start_tm   <= 1'b0;
      r_clear_tm   <= 1'b0;
      r_wen_tm     <= 1'b0;
      r_din_tm     <= '0;
      r_wen_ic     <= 1'b0;
      r_addr_ic    <= '0;
      r_din_ic     <= '0;
      r_wen_mem    <= 1'b0;
      r_addr_mem   <= '0;
      r_din_mem    <= '0;
      r_wen_cle    <= 1'b0;
      r_addr_cle   <= '0;
      r_din_cle    <= '0;
    end else begin
      r_wen_tm   <= 1'b0;
      r_wen_ic   <= 1'b0;
      r_wen_mem  <= 1'b0;
      r_wen_cle  <= 1'b0;
      r_clear_tm <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_host_ready <= 1'b1;
          r_busy       <= 1'b0;
          if (w_accept) begin
            case (host_cmd)
              CMD_TM: begin
                r_wen_tm <= 1'b1;
                r_din_tm <= host_data[TM_DATA_W-1:0];
              end
              CMD_ICACHE: begin
                r_wen_ic  <= 1'b1;
                r_addr_ic <= r_ic_ptr;
                r_din_ic  <= host_data[ICACHE_DATA_W-1:0];
                r_ic_ptr  <= r_ic_ptr + 1'b1;
                if (&r_ic_ptr) r_overflow <= 1'b1;
              end
              CMD_MEM: begin
                r_wen_mem  <= 1'b1;
                r_addr_mem <= r_mem_ptr;
                r_din_mem  <= host_data[MEM_DATA_W-1:0];
                r_mem_ptr  <= r_mem_ptr + 1'b1;
                if (&r_mem_ptr) r_overflow <= 1'b1;
              end
              CMD_CLE: begin
                r_wen_cle  <= 1'b1;
                r_addr_cle <= r_cle_ptr;
                r_din_cle  <= host_data[CLE_DATA_W-1:0];
                r_cle_ptr  <= r_cle_ptr + 1'b1;
                if (&r_cle_ptr) r_overflow <= 1'b1;
              end
              CMD_GO: begin
                r_state      <= ST_CLR;
                r_host_ready <= 1'b0;
                r_busy       <= 1'b1;
                r_clear_tm   <= 1'b1;
                r_done       <= 1'b0;
              end
              CMD_CLEAR: begin
                r_ic_ptr   <= '0;
                r_mem_ptr  <= '0;
                r_cle_ptr  <= '0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
                r_clear_tm <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_CLR: begin
          r_start_tm <= 1'b1;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (w_dump_start) begin
            r_start_tm <= 1'b0;
            r_state    <= ST_DUMP_RD;
          end
          if (w_rd_req) r_addr_mem <= w_rd_addr;
        end
        ST_DUMP_RD: begin
          if (w_rd_req) r_addr_mem <= w_rd_addr;
          if (w_dump_done) begin
            r_done       <= 1'b1;
            r_host_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host_ready      = r_host_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign overflow        = r_overflow;
  assign start_FIO_TM    = r_start_tm;
  assign clear_FIO_TM    = r_clear_tm;
  assign Wen_FIO_TM      = r_wen_tm;
  assign Din_FIO_TM      = r_din_tm;
  assign Wen_FIO_ICache  = r_wen_ic;
  assign Addr_FIO_ICache = r_addr_ic;
  assign Din_FIO_ICache  = r_din_ic;
  assign Wen_FIO_MEM     = r_wen_mem;
  assign Addr_FIO_MEM    = r_addr_mem;
  assign Din_FIO_MEM     = r_din_mem;
  assign Wen_FIO_CLE     = r_wen_cle;
  assign Addr_FIO_CLE    = r_addr_cle;
  assign Din_FIO_CLE     = r_din_cle;

endmodule

// File: tb/tb_fio_sequencer.sv
// Scoreboard bench for fio_sequencer: FIO writes and dump words are queued at
// issue time and popped/compared by monitors when the DUT presents them.
module tb_fio_sequencer;
  import fio_seq_pkg::*;

  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         host_valid, host_ready;
  logic [2:0]   host_cmd;
  logic [255:0] host_data;
  logic         Wen_FIO_TM, start_FIO_TM, clear_FIO_TM, finished_TM_FIO;
  logic [28:0]  Din_FIO_TM;
  logic         Wen_FIO_ICache;
  logic [9:0]   Addr_FIO_ICache;
  logic [31:0]  Din_FIO_ICache;
  logic         Wen_FIO_MEM;
  logic [8:0]   Addr_FIO_MEM;
  logic [255:0] Din_FIO_MEM, Dout_FIO_MEM;
  logic         Wen_FIO_CLE;
  logic [7:0]   Addr_FIO_CLE;
  logic [4:0]   Din_FIO_CLE;
  logic         dump_valid, dump_ready;
  logic [255:0] dump_data;
  logic         busy, done, overflow, timeout;

  always #5 clk = ~clk;

  fio_sequencer #(
    .MEM_ADDR_W(9), .ICACHE_ADDR_W(10), .CLE_ADDR_W(8),
    .DUMP_WORDS(DW), .WDOG_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_cmd(host_cmd), .host_data(host_data),
    .Wen_FIO_TM(Wen_FIO_TM), .Din_FIO_TM(Din_FIO_TM),
    .start_FIO_TM(start_FIO_TM), .clear_FIO_TM(clear_FIO_TM),
    .finished_TM_FIO(finished_TM_FIO),
    .Wen_FIO_ICache(Wen_FIO_ICache), .Addr_FIO_ICache(Addr_FIO_ICache),
    .Din_FIO_ICache(Din_FIO_ICache),
    .Wen_FIO_MEM(Wen_FIO_MEM), .Addr_FIO_MEM(Addr_FIO_MEM),
    .Din_FIO_MEM(Din_FIO_MEM), .Dout_FIO_MEM(Dout_FIO_MEM),
    .Wen_FIO_CLE(Wen_FIO_CLE), .Addr_FIO_CLE(Addr_FIO_CLE),
    .Din_FIO_CLE(Din_FIO_CLE),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .busy(busy), .done(done), .overflow(overflow), .timeout(timeout)
  );

  // Synchronous BRAM model behind the MEM FIO port
  logic [255:0] mem [0:511];
  always @(posedge clk) begin
    if (Wen_FIO_MEM) mem[Addr_FIO_MEM] <= Din_FIO_MEM;
    Dout_FIO_MEM <= mem[Addr_FIO_MEM];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int           tgt;
    logic [9:0]   addr;
    logic [255:0] data;
  } wr_t;

  wr_t          wr_q[$];
  logic [255:0] dump_q[$];
  int           ic_ptr = 0, mem_ptr = 0, cle_ptr = 0;

  // Write monitor: exactly one Wen at a time, matched in order against wr_q
  always @(negedge clk) begin
    int nw;
    wr_t e;
    int t;
    logic [9:0] a;
    logic [255:0] d;
    if (rst) begin
      nw = int'(Wen_FIO_TM) + int'(Wen_FIO_ICache) + int'(Wen_FIO_MEM) + int'(Wen_FIO_CLE);
      if (nw > 1) begin
        check("wen_onehot", 256'(nw), 256'd1);
      end else if (nw == 1) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 256'(wr_q.size()), 256'd1);
        end else begin
          e = wr_q.pop_front();
          if (Wen_FIO_TM)          begin t = 0; a = '0;                    d = 256'(Din_FIO_TM);     end
          else if (Wen_FIO_ICache) begin t = 1; a = Addr_FIO_ICache;       d = 256'(Din_FIO_ICache); end
          else if (Wen_FIO_MEM)    begin t = 2; a = 10'(Addr_FIO_MEM);     d = Din_FIO_MEM;          end
          else                     begin t = 3; a = 10'(Addr_FIO_CLE);     d = 256'(Din_FIO_CLE);    end
          check("wr_target", 256'(t), 256'(e.tgt));
          check("wr_addr", 256'(a), 256'(e.addr));
          check("wr_data", d, e.data);
          $display("write tgt=%0d addr=%0d data=%0h", t, a, d);
        end
      end
    end
  end

  // Dump consumer: drives dump_ready, checks hold stability and stream order
  int           dump_mode = 2;   // 0: stall word 2 for 5 cycles, 1: never ready, 2: always ready
  int           word_idx = 0;
  int           hold_cnt = 0;
  logic         held_valid = 1'b0;
  logic [255:0] held_data;
  always @(negedge clk) begin
    logic [255:0] ev;
    if (!rst) begin
      dump_ready = 1'b0;
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("dump_hold_valid", 256'(dump_valid), 256'd1);
        check("dump_hold_data", dump_data, held_data);
      end
      case (dump_mode)
        0: begin
          if (dump_valid && word_idx == 2 && hold_cnt < 5) begin
            dump_ready = 1'b0;
            hold_cnt++;
          end else begin
            dump_ready = 1'b1;
          end
        end
        1:       dump_ready = 1'b0;
        default: dump_ready = 1'b1;
      endcase
      held_valid = dump_valid && !dump_ready;
      held_data  = dump_data;
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) begin
          check("dump_unexpected", 256'(dump_q.size()), 256'd1);
        end else begin
          ev = dump_q.pop_front();
          check("dump_word", dump_data, ev);
          $display("dump word %0d data=%0h", word_idx, dump_data);
        end
        word_idx++;
      end
    end
  end

  // Issue one command starting at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [2:0] cmd, input logic [255:0] data);
    bit ok;
    ok = 1'b0;
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_data  = data;
    for (int i = 0; i < 300; i++) begin
      if (host_ready) begin
        case (cmd)
          CMD_TM:     wr_q.push_back('{tgt: 0, addr: 10'd0, data: 256'(data[28:0])});
          CMD_ICACHE: begin wr_q.push_back('{tgt: 1, addr: 10'(ic_ptr), data: 256'(data[31:0])}); ic_ptr = (ic_ptr + 1) % 1024; end
          CMD_MEM:    begin wr_q.push_back('{tgt: 2, addr: 10'(mem_ptr), data: data}); mem_ptr = (mem_ptr + 1) % 512; end
          CMD_CLE:    begin wr_q.push_back('{tgt: 3, addr: 10'(cle_ptr), data: 256'(data[4:0])}); cle_ptr = (cle_ptr + 1) % 256; end
          CMD_CLEAR:  begin ic_ptr = 0; mem_ptr = 0; cle_ptr = 0; end
          default: ;
        endcase
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("host_accept", 256'(host_ready), 256'd1);
    @(negedge clk);
    host_valid = 1'b0;
    $display("cmd %0d data=%0h accepted=%0d", cmd, data, ok);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check(name, 256'(done), 256'd1);
  endtask

  task automatic push_dump();
    word_idx = 0;
    hold_cnt = 0;
    for (int k = 0; k < DW; k++) dump_q.push_back(256'(k));
  endtask

  initial begin
    int bad;
    int cnt;
    host_valid = 1'b0;
    host_cmd = '0;
    host_data = '0;
    finished_TM_FIO = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_host_ready", 256'(host_ready), 256'd0);
    check("rst_status", 256'({busy, done, overflow, timeout}), 256'd0);
    check("rst_tm_ctrl", 256'({start_FIO_TM, clear_FIO_TM}), 256'd0);
    check("rst_wen", 256'({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE}), 256'd0);
    check("rst_dump_valid", 256'(dump_valid), 256'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_host_ready", 256'(host_ready), 256'd1);

    send(CMD_ICACHE, 256'hA);
    send(CMD_ICACHE, 256'hB);
    send(CMD_ICACHE, 256'hC);
    send(CMD_TM, {256{1'b1}});
    send(CMD_CLE, 256'h3F);
    send(CMD_CLE, 256'h2A);

    for (int k = 0; k < 513; k++) begin
      if (k == 511) check("overflow_before_wrap", 256'(overflow), 256'd0);
      send(CMD_MEM, (k == 512) ? 256'hBEEF : 256'(k));
    end
    @(negedge clk);
    check("overflow_after_wrap", 256'(overflow), 256'd1);

    send(CMD_CLEAR, 256'd0);
    check("clear_pulse", 256'(clear_FIO_TM), 256'd1);
    check("clear_overflow", 256'(overflow), 256'd0);
    check("clear_stays_idle", 256'(host_ready), 256'd1);
    @(negedge clk);
    check("clear_pulse_end", 256'(clear_FIO_TM), 256'd0);
    for (int k = 0; k < DW; k++) send(CMD_MEM, 256'(k));
    send(3'd6, 256'h55);
    send(3'd7, 256'h66);
    check("unknown_cmd_idle", 256'({host_ready, busy}), 256'b10);

    // GO with finished raised 20 cycles after acceptance
    push_dump();
    dump_mode = 0;
    send(CMD_GO, 256'd0);
    check("go_clear_pulse", 256'({clear_FIO_TM, start_FIO_TM}), 256'b10);
    check("go_busy", 256'({host_ready, busy}), 256'b01);
    @(negedge clk);
    check("go_start", 256'({clear_FIO_TM, start_FIO_TM}), 256'b01);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (start_FIO_TM !== 1'b1 || host_ready !== 1'b0 || clear_FIO_TM !== 1'b0) bad++;
    end
    check("run_span", 256'(bad), 256'd0);
    finished_TM_FIO = 1'b1;
    @(negedge clk);
    finished_TM_FIO = 1'b0;
    check("finish_start_low", 256'(start_FIO_TM), 256'd0);
    check("finish_addr0", 256'(Addr_FIO_MEM), 256'd0);
    check("finish_host_ready", 256'(host_ready), 256'd0);
    wait_done("dump_done");
    check("done_idle", 256'({host_ready, busy}), 256'b10);
    check("dump_all_words", 256'(dump_q.size()), 256'd0);
    send(CMD_CLEAR, 256'd0);
    check("clear_done", 256'(done), 256'd0);

`ifdef FIO_WATCHDOG_EN
    push_dump();
    dump_mode = 2;
    send(CMD_GO, 256'd0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_FIO_TM) cnt++;
      if (timeout) break;
    end
    check("wdog_timeout", 256'(timeout), 256'd1);
    check("wdog_run_len", 256'(cnt), 256'd50);
    wait_done("wdog_dump_done");
    check("wdog_dump_words", 256'(dump_q.size()), 256'd0);
    send(CMD_CLEAR, 256'd0);
`endif

    // Reset asserted while a word sits in DUMP_OUT
    dump_mode = 1;
    send(CMD_GO, 256'd0);
    repeat (3) @(negedge clk);
    finished_TM_FIO = 1'b1;
    @(negedge clk);
    finished_TM_FIO = 1'b0;
    for (int i = 0; i < 20 && !dump_valid; i++) @(negedge clk);
    check("abort_reached_out", 256'(dump_valid), 256'd1);
    rst = 1'b0;
    #1;
    check("abort_dump_valid", 256'(dump_valid), 256'd0);
    check("abort_status", 256'({host_ready, busy, done, start_FIO_TM}), 256'd0);
    check("abort_mem_port", 256'({Wen_FIO_MEM, Addr_FIO_MEM}), 256'd0);
    @(negedge clk);
    ic_ptr = 0; mem_ptr = 0; cle_ptr = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    push_dump();
    dump_mode = 2;
    send(CMD_GO, 256'd0);
    repeat (4) @(negedge clk);
    finished_TM_FIO = 1'b1;
    @(negedge clk);
    finished_TM_FIO = 1'b0;
    check("rerun_addr0", 256'(Addr_FIO_MEM), 256'd0);
    wait_done("rerun_done");
    check("rerun_dump_words", 256'(dump_q.size()), 256'd0);
    check("writes_all_seen", 256'(wr_q.size()), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
